// File: rtl/axis_if.sv
// Minimal AXI-Stream channel (valid/ready/data) shared by the front-end blocks.
// Width is set per instance so one definition covers both redirect and fetch channels.
interface axis_if #(
    parameter int W = 32
);
    logic         tvalid;
    logic         tready;
    logic [W-1:0] tdata;

    modport m (output tvalid, output tdata, input tready);
    modport s (input tvalid, input tdata, output tready);
endinterface

// File: rtl/pc_generator.sv
// Program counter generator: owns the fetch PC, streams sequential fetch requests tagged
// with an epoch, and applies committer redirects with a same-cycle flush to fetch.
module pc_generator #(
    parameter int                XLEN         = 32,
    parameter logic [XLEN-1:0]   RESET_VECTOR = XLEN'(32'h8000_0000),
    parameter int                EPOCH_W      = 2,
    parameter int                MAX_INFLIGHT = 4
) (
    input  logic clk,
    input  logic rst,
    axis_if.s    wbpcg_axis_if,
    axis_if.m    pcif_axis_if,
    input  logic fetch_done,
    output logic flush
);

    localparam logic [0:0] BOOT = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    logic [0:0]         state;
    logic [XLEN-1:0]    pc;
    logic [EPOCH_W-1:0] epoch;
    logic [3:0]         inflight;

    logic            run;
    logic            redirect;
    logic            accept;
    logic [XLEN-1:0] target;

    // Outputs are pure functions of state, so asserting rst clears them without a clock.
    assign run      = (state == RUN);
    assign redirect = run && wbpcg_axis_if.tvalid;
    assign accept   = pcif_axis_if.tvalid && pcif_axis_if.tready;
    assign target   = wbpcg_axis_if.tdata & ~XLEN'(3);

    assign wbpcg_axis_if.tready = run;
    assign pcif_axis_if.tvalid  = run && (inflight < 4'(MAX_INFLIGHT));
    assign pcif_axis_if.tdata   = {epoch, pc};
    assign flush                = redirect;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= BOOT;
            pc    <= RESET_VECTOR;
            epoch <= '0;
        end else if (state == BOOT) begin
            state <= RUN;
        end else if (redirect) begin
            pc    <= target;
            epoch <= epoch + EPOCH_W'(1);
        end else if (accept) begin
            pc    <= pc + XLEN'(4);
        end
    end

    // Squashed requests still retire through fetch_done, so flushes never touch this count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inflight <= '0;
        end else begin
            case ({accept, fetch_done})
                2'b10:   inflight <= inflight + 4'd1;
                2'b01:   inflight <= inflight - 4'd1;
                default: inflight <= inflight;
            endcase
        end
    end

    a_no_underflow: assert property (@(posedge clk) disable iff (!rst)
        !(fetch_done && (inflight == 4'd0)));

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
        inflight <= 4'(MAX_INFLIGHT));

endmodule
